// File: rtl/sched_pkg.sv
// Shared types and default constants for the resource scheduler.
//   owner_e : which pipeline owns an in-flight request (P1 = 0, P2 = 1)
//   tag_t   : owner tag held in the in-flight FIFO; alive=0 means drop the result
package sched_pkg;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   alive;
  } tag_t;

  localparam int DEF_LATENCY         = 2;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_MAX_WAIT        = 8;

endpackage

// File: rtl/resource_scheduler_if.sv
// Handshake bundle between two pipelines, the shared resource and the scheduler.
//   master : pipelines/resource side (drives requests, flushes, result valid)
//   slave  : scheduler side (drives grants, stalls, issue info, routed responses)
interface resource_scheduler_if;

  logic req_1;
  logic req_2;
  logic flush_1;
  logic flush_2;
  logic res_valid;
  logic grant_1;
  logic grant_2;
  logic stall_1;
  logic stall_2;
  logic issue_valid;
  logic issue_sel;
  logic rsp_valid_1;
  logic rsp_valid_2;
  logic busy;
  logic err_underflow;

  modport master (
    output req_1, req_2, flush_1, flush_2, res_valid,
    input  grant_1, grant_2, stall_1, stall_2, issue_valid, issue_sel,
           rsp_valid_1, rsp_valid_2, busy, err_underflow
  );

  modport slave (
    input  req_1, req_2, flush_1, flush_2, res_valid,
    output grant_1, grant_2, stall_1, stall_2, issue_valid, issue_sel,
           rsp_valid_1, rsp_valid_2, busy, err_underflow
  );

endinterface

// File: rtl/owner_tag_fifo.sv
// In-flight owner-tag FIFO with kill-by-owner.
//   clk, reset           : clock, asynchronous active-low reset
//   push, push_owner     : enqueue a live tag for the given owner
//   pop                  : dequeue head (ignored when empty)
//   flush_1, flush_2     : clear alive on every entry owned by that pipe
//   head, empty, full    : head tag and occupancy flags
//   count                : number of entries held
module owner_tag_fifo
  import sched_pkg::*;
#(
  parameter  int DEPTH = DEF_MAX_OUTSTANDING,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  owner_e           push_owner,
  input  logic             pop,
  input  logic             flush_1,
  input  logic             flush_2,
  output tag_t             head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((mem[i].owner == OWNER_P1 && flush_1) ||
            (mem[i].owner == OWNER_P2 && flush_2))
          mem[i].alive <= 1'b0;
      end
      // A fresh push overrides the kill above for its slot; a pipe being
      // flushed never gets a grant, so the new tag is never a flushed one.
      if (do_push) begin
        mem[wr_ptr].owner <= push_owner;
        mem[wr_ptr].alive <= 1'b1;
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/resource_scheduler.sv
// Two-pipeline arbiter for one shared fixed-latency resource.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of resource_scheduler_if (requests, flushes, result
//           valid in; grants, stalls, issue info, routed responses, busy,
//           sticky underflow error out)
// Grants are round-robin with a starvation override; every grant records its
// owner in owner_tag_fifo so the in-order results can be routed back.
module resource_scheduler
  import sched_pkg::*;
#(
  parameter int LATENCY         = DEF_LATENCY,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  resource_scheduler_if.slave   bus
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  if (LATENCY < 1 || MAX_OUTSTANDING < 1 || MAX_WAIT < 1) begin : g_param_check
    $error("resource_scheduler: LATENCY, MAX_OUTSTANDING and MAX_WAIT must be >= 1");
  end

  logic              eff_1, eff_2;
  logic              starved_1, starved_2;
  logic              pick_2;
  logic              grant_1, grant_2;
  logic              rr_ptr;       // 0 favours pipe1, 1 favours pipe2
  logic [WAIT_W-1:0] wait_1, wait_2;
  logic              err_q;

  tag_t              head;
  logic              empty, full;
  logic [CNT_W-1:0]  count;
  logic              pop;

  always_comb begin
    eff_1     = bus.req_1 & ~bus.flush_1;
    eff_2     = bus.req_2 & ~bus.flush_2;
    starved_1 = (wait_1 == WAIT_W'(MAX_WAIT));
    starved_2 = (wait_2 == WAIT_W'(MAX_WAIT));
    pick_2    = (starved_1 != starved_2) ? starved_2 : rr_ptr;
    grant_1   = 1'b0;
    grant_2   = 1'b0;
    // A full FIFO blocks issue even when a result frees a slot this cycle.
    if (reset && !full) begin
      if (eff_1 && eff_2) begin
        grant_1 = ~pick_2;
        grant_2 = pick_2;
      end else begin
        grant_1 = eff_1;
        grant_2 = eff_2;
      end
    end
  end

  assign pop = reset & bus.res_valid & ~empty;

  always_comb begin
    bus.grant_1       = grant_1;
    bus.grant_2       = grant_2;
    bus.stall_1       = reset & eff_1 & ~grant_1;
    bus.stall_2       = reset & eff_2 & ~grant_2;
    bus.issue_valid   = grant_1 | grant_2;
    bus.issue_sel     = grant_2;
    // A result popping while its owner flushes is dropped.
    bus.rsp_valid_1   = pop & head.alive & (head.owner == OWNER_P1) & ~bus.flush_1;
    bus.rsp_valid_2   = pop & head.alive & (head.owner == OWNER_P2) & ~bus.flush_2;
    bus.busy          = reset & (count != '0);
    bus.err_underflow = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
      wait_1 <= '0;
      wait_2 <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant_1)      rr_ptr <= 1'b1;
      else if (grant_2) rr_ptr <= 1'b0;

      if (eff_1 && !grant_1) wait_1 <= starved_1 ? wait_1 : wait_1 + 1'b1;
      else                   wait_1 <= '0;
      if (eff_2 && !grant_2) wait_2 <= starved_2 ? wait_2 : wait_2 + 1'b1;
      else                   wait_2 <= '0;

      if (bus.res_valid && empty) err_q <= 1'b1;
    end
  end

  owner_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (grant_1 | grant_2),
    .push_owner (grant_2 ? OWNER_P2 : OWNER_P1),
    .pop        (pop),
    .flush_1    (bus.flush_1),
    .flush_2    (bus.flush_2),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .count      (count)
  );

endmodule

// File: tb/tb_resource_scheduler.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_resource_scheduler;
  import sched_pkg::*;

  localparam int LAT = 2;
  localparam int MO  = 4;
  localparam int MW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  resource_scheduler_if bus ();

  resource_scheduler #(
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MO),
    .MAX_WAIT        (MW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: in-flight results as a plain queue of owners.
  typedef struct {
    int owner;   // 1 or 2
    bit alive;
  } mtag_t;

  typedef struct {
    int         cyc;
    logic [9:0] v;  // g1 g2 s1 s2 issue_valid issue_sel rsp1 rsp2 busy err
  } exp_t;

  mtag_t tags[$];
  exp_t  expq[$];
  int    res_due[$];
  int    favour  = 1;
  int    wt1     = 0;
  int    wt2     = 0;
  bit    merr    = 0;
  bit    auto_res = 0;
  int    cyc     = 0;
  int    checks  = 0;
  int    errors  = 0;

  task automatic model_reset();
    tags.delete();
    res_due.delete();
    favour = 1;
    wt1    = 0;
    wt2    = 0;
    merr   = 0;
  endtask

  task automatic step(input bit r1, input bit r2, input bit f1, input bit f2,
                      input bit rv, input bit rst_n);
    bit    e1, e2, g1, g2, rsp1, rsp2, busy_e, err_e, rv_eff, s1, s2;
    mtag_t hd, nt;
    exp_t  ex;
    @(posedge clk);
    #1;
    cyc++;
    rv_eff = rv;
    if (auto_res && res_due.size() > 0 && res_due[0] == cyc) begin
      void'(res_due.pop_front());
      rv_eff = 1'b1;
    end
    bus.req_1     = r1;
    bus.req_2     = r2;
    bus.flush_1   = f1;
    bus.flush_2   = f2;
    bus.res_valid = rv_eff;
    reset         = rst_n;
    ex.cyc = cyc;
    if (!rst_n) begin
      model_reset();
      ex.v = '0;
      expq.push_back(ex);
      return;
    end
    e1 = r1 && !f1;
    e2 = r2 && !f2;
    g1 = 0;
    g2 = 0;
    if (tags.size() < MO) begin
      if (e1 && e2) begin
        s1 = (wt1 == MW);
        s2 = (wt2 == MW);
        if (s1 && !s2)      g1 = 1;
        else if (s2 && !s1) g2 = 1;
        else if (favour == 1) g1 = 1;
        else                g2 = 1;
      end else begin
        g1 = e1;
        g2 = e2;
      end
    end
    busy_e = (tags.size() != 0);
    err_e  = merr;
    rsp1   = 0;
    rsp2   = 0;
    if (rv_eff) begin
      if (tags.size() == 0) merr = 1;
      else begin
        hd = tags.pop_front();
        rsp1 = hd.alive && hd.owner == 1 && !f1;
        rsp2 = hd.alive && hd.owner == 2 && !f2;
      end
    end
    ex.v = {g1, g2, e1 && !g1, e2 && !g2, g1 || g2, g2, rsp1, rsp2, busy_e, err_e};
    expq.push_back(ex);
    foreach (tags[i]) begin
      if ((tags[i].owner == 1 && f1) || (tags[i].owner == 2 && f2)) tags[i].alive = 0;
    end
    nt.alive = 1;
    if (g1) begin nt.owner = 1; tags.push_back(nt); favour = 2; end
    if (g2) begin nt.owner = 2; tags.push_back(nt); favour = 1; end
    wt1 = (e1 && !g1) ? ((wt1 < MW) ? wt1 + 1 : MW) : 0;
    wt2 = (e2 && !g2) ? ((wt2 < MW) ? wt2 + 1 : MW) : 0;
    if (auto_res && (g1 || g2)) res_due.push_back(cyc + LAT);
  endtask

  task automatic idle(input int n, input bit rv);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rv, 1);
  endtask

  // Monitor: compare every presented output set against the scoreboard.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {bus.grant_1, bus.grant_2, bus.stall_1, bus.stall_2, bus.issue_valid,
               bus.issue_sel, bus.rsp_valid_1, bus.rsp_valid_2, bus.busy,
               bus.err_underflow};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b expected %b (g1 g2 s1 s2 iv isel r1 r2 busy err)",
                   e.cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    bus.req_1 = 0; bus.req_2 = 0; bus.flush_1 = 0; bus.flush_2 = 0; bus.res_valid = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Both pipes requesting, results LAT cycles after issue: alternating grants.
    auto_res = 1;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 1);
    idle(4, 0);
    auto_res = 0;

    // Single requester fills the FIFO, then one result frees a slot.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    idle(4, 1);

    // Starvation: pipe2 blocked by a full FIFO while pointer favours pipe1.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1);
    idle(4, 1);

    // Flush kills pipe1's in-flight results.
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    idle(3, 1);

    // Underflow is sticky.
    idle(1, 1);
    idle(3, 0);

    // Reset with results outstanding, then a late result underflows.
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    idle(1, 0);
    idle(1, 1);
    idle(2, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r1, r2, f1, f2, rv, rn;
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      f1 = ($urandom_range(0, 15) == 0);
      f2 = ($urandom_range(0, 15) == 0);
      if (tags.size() > 0) rv = ($urandom_range(0, 2) != 0);
      else                 rv = ($urandom_range(0, 63) == 0);
      rn = ($urandom_range(0, 199) != 0);
      step(r1, r2, f1, f2, rv, rn);
    end
    idle(2, 0);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resource_scheduler.md
RESOURCE_SCHEDULER -- requirements
Module: resource_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 2: fixed cycles from issue to resource result, informational, used only by bench checks.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: depth of in-flight owner-tag FIFO.
REQ-003 SHALL have parameter MAX_WAIT, default 8: consecutive denied cycles before a requester is starved.
REQ-004 SHALL have ports: clk input 1 (sole clock, rising edge); reset input 1 (asynchronous, active-low).
REQ-005 SHALL have ports: req_1, req_2 input 1 each (pipeline requests for shared resource).
REQ-006 SHALL have ports: flush_1, flush_2 input 1 each (pipeline flush, kills own requests and in-flight results).
REQ-007 SHALL have ports: res_valid input 1 (shared resource result valid).
REQ-008 SHALL have ports: grant_1, grant_2 output 1 each (combinational, one-hot or zero).
REQ-009 SHALL have ports: stall_1, stall_2 output 1 each (request pending but not granted).
REQ-010 SHALL have ports: issue_valid output 1 (= grant_1|grant_2) and issue_sel output 1 (0=pipe1, 1=pipe2; 0 when idle).
REQ-011 SHALL have ports: rsp_valid_1, rsp_valid_2 output 1 each (routed result valid).
REQ-012 SHALL have ports: busy output 1 (outstanding count nonzero) and err_underflow output 1 (sticky).

Function
REQ-013 Effective request eff_x SHALL be req_x & ~flush_x.
REQ-014 Grant SHALL be blocked (both grants 0) when outstanding count == MAX_OUTSTANDING, even if res_valid is high that cycle.
REQ-015 Priority: a starved requester (wait_x == MAX_WAIT) wins; if both or neither starved, round-robin pointer decides (pointer=0 favours pipe1).
REQ-016 On each cycle with a grant, pointer SHALL move to favour the non-granted requester next cycle; no grant leaves pointer unchanged.
REQ-017 wait_x SHALL increment (saturating at MAX_WAIT) when eff_x & ~grant_x, and clear to 0 on grant_x or ~eff_x.
REQ-018 stall_x SHALL equal eff_x & ~grant_x.
REQ-019 Each grant SHALL push owner tag {owner, alive=1} into tag FIFO on the same clock edge.
REQ-020 res_valid SHALL pop FIFO head; rsp_valid_x SHALL be asserted combinationally in that cycle when head owner==x and alive==1, else dropped silently.
REQ-021 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-022 flush_x SHALL clear alive on every FIFO entry owned by x at the clock edge; a result popping that same cycle SHALL be dropped (rsp_valid_x=0).
REQ-023 res_valid with empty FIFO SHALL set err_underflow, change no other state, and drive no rsp_valid.
REQ-024 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING; count width SHALL be clog2(MAX_OUTSTANDING+1).

Reset
REQ-025 On reset low, SHALL immediately clear: pointer=0, wait_1/wait_2=0, FIFO pointers/count=0, all alive bits=0, err_underflow=0.
REQ-026 During reset, grant_x, stall_x, issue_valid, issue_sel, rsp_valid_x and busy SHALL all be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight tags; results arriving after release SHALL count as underflow.

Structure
REQ-028 Owner encoding (OWNER_P1=0, OWNER_P2=1), tag struct and default parameter constants SHALL live in shared package sched_pkg.
REQ-029 Tag FIFO with per-entry kill-by-owner SHALL be one sub-module, owner_tag_fifo; arbitration logic stays in top.

Verification
REQ-030 Both req held high from reset release, res_valid 2 cycles after each issue -> grants alternate 1,2,1,2; rsp_valid alternates matching.
REQ-031 req_1 only, no res_valid for 5 cycles -> 4 grants, then grant_1=0, stall_1=1, busy=1; first res_valid -> rsp_valid_1=1, grant resumes next cycle.
REQ-032 req_2 high, req_1 high, pointer forced toward pipe1 with FIFO kept blocking pipe2 8 cycles -> starve priority: pipe2 granted first cycle unblocked.
REQ-033 Issue 1,2,1 then flush_1 -> subsequent three res_valid yield only rsp_valid_2 on second pop.
REQ-034 res_valid with busy=0 -> err_underflow=1 sticky until reset; no rsp_valid.
REQ-035 Reset asserted with 3 outstanding -> busy=0 same cycle; after release, first res_valid sets err_underflow.
